axi_burst_read_master: RTL and testbench

AXI4 read-channel master that turns one CPU-side read request into a single INCR burst of 1..MAX_BEATS beats. It drives AR/R toward the interconnect, streams each returned beat to the requester with a strobe and index, and reports SLVERR/DECERR, protocol and (optionally) timeout errors. It replaces the single-beat read master at the IM/DM ports and is the base for cache-line refill.

---
 rtl/axi_rd_pkg.sv | 28 ++
 rtl/axi_rd_watchdog.sv | 30 +++
 rtl/axi_burst_read_master.sv | 185 ++++++++++++++++++
 tb/tb_axi_burst_read_master.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rd_pkg.sv
// Shared types and AXI constants for the burst read master and its watchdog.
package axi_rd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_INCR = 2'b01;

  // ARSIZE encoding for a full-width beat: log2 of the byte count.
  function automatic logic [2:0] axi_size(input int data_w);
    logic [2:0] s;
    s = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if ((1 << i) == (data_w / 8)) s = 3'(i);
    end
    return s;
  endfunction

endpackage

// File: rtl/axi_rd_watchdog.sv
// Down-counting stall watchdog: reloads on load, counts while en, flags expire at terminal count.
module axi_rd_watchdog #(
  parameter int LIMIT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] TC_START = CW'(LIMIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= TC_START;
    end else if (load) begin
      cnt <= TC_START;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  // A handshake in the terminal cycle wins over the timeout.
  assign expire = en && !load && (cnt == '0);

endmodule

// File: rtl/axi_burst_read_master.sv
// AXI4 read master: one requester read becomes a single INCR burst of 1..MAX_BEATS beats.
// Define AXI_RD_TIMEOUT_EN to add a watchdog that aborts a stalled burst into DONE with err_o[1].
//
// state | meaning
// IDLE  | no burst, ARID parked on IDLE_ID
// AR    | address phase, ARVALID held until ARREADY
// R     | data phase, beats streamed until RLAST
// DONE  | burst finished, last beat and errors held
module axi_burst_read_master
  import axi_rd_pkg::*;
#(
  parameter int ID_W        = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_BEATS   = 16,
  parameter int LEN_W       = (MAX_BEATS > 2) ? $clog2(MAX_BEATS) : 1,
  parameter logic [ID_W-1:0] MY_ID   = 4'b0001,
  parameter logic [ID_W-1:0] IDLE_ID = 4'b0010,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic              hold_i,
  output logic              busy_o,
  output logic              beat_o,
  output logic [LEN_W-1:0]  beat_idx_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic [1:0]        err_o,
  output logic              done_o,
  output logic [ID_W-1:0]   ARID,
  output logic [ADDR_W-1:0] ARADDR,
  output logic [7:0]        ARLEN,
  output logic [2:0]        ARSIZE,
  output logic [1:0]        ARBURST,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic [ID_W-1:0]   RID,
  input  logic [DATA_W-1:0] RDATA,
  input  logic [1:0]        RRESP,
  input  logic              RLAST,
  input  logic              RVALID,
  output logic              RREADY
);

  state_t             state;
  logic               ar_valid_q;
  logic               r_ready_q;
  logic               beat_q;
  logic               done_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   idx_q;
  logic [LEN_W:0]     cnt;
  logic [DATA_W-1:0]  rdata_q;
  logic [1:0]         err_q;
  logic               ar_hs;
  logic               r_hs;
  logic               resp_bad;
  logic               id_bad;
  logic               start;
  logic               wd_expire;

  assign ar_hs    = ar_valid_q & ARREADY;
  assign r_hs     = r_ready_q & RVALID;
  assign resp_bad = (RRESP == RESP_SLVERR) || (RRESP == RESP_DECERR) || (RRESP == RESP_EXOKAY);
  assign id_bad   = (RID != MY_ID);
  assign start    = req_i && ((state == ST_IDLE) || ((state == ST_DONE) && !hold_i));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      ar_valid_q <= 1'b0;
      r_ready_q  <= 1'b0;
      beat_q     <= 1'b0;
      done_q     <= 1'b0;
      len_q      <= '0;
      idx_q      <= '0;
      cnt        <= '0;
      rdata_q    <= '0;
      err_q      <= '0;
    end else begin
      beat_q <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state      <= ST_AR;
            ar_valid_q <= 1'b1;
            done_q     <= 1'b0;
            len_q      <= len_i;
            cnt        <= '0;
            err_q      <= '0;
          end else if (!((state == ST_DONE) && hold_i)) begin
            state  <= ST_IDLE;
            done_q <= 1'b0;
          end
        end
        ST_AR: begin
          if (ar_hs) begin
            state      <= ST_R;
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b1;
          end else if (wd_expire) begin
            state      <= ST_DONE;
            ar_valid_q <= 1'b0;
            done_q     <= 1'b1;
            err_q[1]   <= 1'b1;
          end
        end
        ST_R: begin
          if (r_hs) begin
            rdata_q <= RDATA;
            idx_q   <= cnt[LEN_W-1:0];
            beat_q  <= 1'b1;
            if (cnt != '1) cnt <= cnt + 1'b1;
            // Overrun, short burst, bad response or foreign ID all fold into err[0].
            if (resp_bad || id_bad || (cnt > {1'b0, len_q}) ||
                (RLAST && (cnt != {1'b0, len_q}))) begin
              err_q[0] <= 1'b1;
            end
            if (RLAST) begin
              state     <= ST_DONE;
              r_ready_q <= 1'b0;
              done_q    <= 1'b1;
            end
          end else if (wd_expire) begin
            state     <= ST_DONE;
            r_ready_q <= 1'b0;
            done_q    <= 1'b1;
            err_q[1]  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef AXI_RD_TIMEOUT_EN
  logic wd_en;
  logic wd_load;

  assign wd_en   = (state == ST_AR) || (state == ST_R);
  assign wd_load = !wd_en || ar_hs || r_hs;

  axi_rd_watchdog #(
    .LIMIT (TIMEOUT_CYC)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .load   (wd_load),
    .en     (wd_en),
    .expire (wd_expire)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC == 0);
  assign wd_expire = 1'b0;
`endif

  always_comb begin
    busy_o = 1'b0;
    case (state)
      ST_IDLE: busy_o = req_i;
      ST_AR:   busy_o = 1'b1;
      ST_R:    busy_o = 1'b1;
      default: busy_o = 1'b0;
    endcase
  end

  assign beat_o     = beat_q;
  assign beat_idx_o = idx_q;
  assign rdata_o    = rdata_q;
  assign err_o      = err_q;
  assign done_o     = done_q;

  assign ARID    = (state == ST_IDLE) ? IDLE_ID : MY_ID;
  assign ARADDR  = ar_valid_q ? addr_i : '0;
  assign ARLEN   = ar_valid_q ? 8'(len_q) : 8'd0;
  assign ARSIZE  = axi_size(DATA_W);
  assign ARBURST = BURST_INCR;
  assign ARVALID = ar_valid_q;
  assign RREADY  = r_ready_q;

endmodule

// File: tb/tb_axi_burst_read_master.sv
// Self-checking bench for axi_burst_read_master: burst table plus hand sequences, beat scoreboard.
module tb_axi_burst_read_master;

  localparam int ID_W = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LEN_W = 4;
  localparam logic [ID_W-1:0] MY_ID = 4'b0001;
  localparam logic [ID_W-1:0] IDLE_ID = 4'b0010;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic req_i = 1'b0;
  logic [ADDR_W-1:0] addr_i = '0;
  logic [LEN_W-1:0] len_i = '0;
  logic hold_i = 1'b0;
  logic busy_o, beat_o, done_o;
  logic [LEN_W-1:0] beat_idx_o;
  logic [DATA_W-1:0] rdata_o;
  logic [1:0] err_o;
  logic [ID_W-1:0] ARID;
  logic [ADDR_W-1:0] ARADDR;
  logic [7:0] ARLEN;
  logic [2:0] ARSIZE;
  logic [1:0] ARBURST;
  logic ARVALID;
  logic ARREADY = 1'b0;
  logic [ID_W-1:0] RID = MY_ID;
  logic [DATA_W-1:0] RDATA = '0;
  logic [1:0] RRESP = 2'b00;
  logic RLAST = 1'b0;
  logic RVALID = 1'b0;
  logic RREADY;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    int                len;
    int                ar_dly;
    int                nbeats;
    int                bad_beat;
    logic [1:0]        bad_resp;
    int                bad_id_beat;
    int                gap;
    logic [1:0]        exp_err;
  } vec_t;

  typedef struct {
    logic [LEN_W-1:0]  idx;
    logic [DATA_W-1:0] data;
  } beat_t;

  beat_t sb[$];
  vec_t  tbl[10];

  axi_burst_read_master #(
    .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BEATS(16), .LEN_W(LEN_W),
    .MY_ID(MY_ID), .IDLE_ID(IDLE_ID), .TIMEOUT_CYC(8)
  ) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .addr_i(addr_i), .len_i(len_i), .hold_i(hold_i),
    .busy_o(busy_o), .beat_o(beat_o), .beat_idx_o(beat_idx_o), .rdata_o(rdata_o),
    .err_o(err_o), .done_o(done_o),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every beat_o must match the oldest beat the slave model handed over.
  always @(negedge clk) begin
    if (rst && beat_o) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL beat_unexpected actual=idx%0h required=no_beat", beat_idx_o);
      end else begin
        beat_t e;
        e = sb.pop_front();
        chk("beat_idx", 64'(beat_idx_o), 64'(e.idx));
        chk("beat_data", 64'(rdata_o), 64'(e.data));
      end
    end
  end

  task automatic run_burst(input vec_t v);
    logic ok;
    hold_i = 1'b0;
    addr_i = v.addr;
    len_i  = LEN_W'(v.len);
    req_i  = 1'b1;
    step();
    req_i = 1'b0;
    chk("arvalid_up", 64'(ARVALID), 64'd1);
    chk("err_cleared", 64'(err_o), 64'd0);
    chk("arlen", 64'(ARLEN), 64'(v.len));
    chk("araddr", 64'(ARADDR), 64'(v.addr));
    chk("arid_active", 64'(ARID), 64'(MY_ID));
    ok = 1'b1;
    for (int i = 0; i < v.ar_dly; i++) begin
      step();
      if (ARVALID !== 1'b1 || ARLEN !== 8'(v.len) || busy_o !== 1'b1) ok = 1'b0;
    end
    chk("ar_stable", 64'(ok), 64'd1);
    ARREADY = 1'b1;
    step();
    ARREADY = 1'b0;
    chk("arvalid_down", 64'(ARVALID), 64'd0);
    ok = 1'b1;
    for (int b = 0; b < v.nbeats; b++) begin
      beat_t e;
      for (int g = 0; g < v.gap; g++) step();
      if (RREADY !== 1'b1 || busy_o !== 1'b1 || done_o !== 1'b0) ok = 1'b0;
      RVALID = 1'b1;
      RDATA  = $urandom;
      RRESP  = (b == v.bad_beat) ? v.bad_resp : 2'b00;
      RID    = (b == v.bad_id_beat) ? 4'h7 : MY_ID;
      RLAST  = (b == v.nbeats - 1);
      e.idx  = LEN_W'(b);
      e.data = RDATA;
      sb.push_back(e);
      step();
      RVALID = 1'b0;
      RLAST  = 1'b0;
      RRESP  = 2'b00;
      RID    = MY_ID;
    end
    chk("r_phase", 64'(ok), 64'd1);
    chk("done_up", 64'(done_o), 64'd1);
    chk("busy_done", 64'(busy_o), 64'd0);
    chk("last_beat_in_done", 64'(beat_o), 64'd1);
    chk("rready_done", 64'(RREADY), 64'd0);
    chk("err_done", 64'(err_o), 64'(v.exp_err));
  endtask

  task automatic go_idle();
    hold_i = 1'b0;
    req_i  = 1'b0;
    step();
    chk("idle_done", 64'(done_o), 64'd0);
    chk("idle_arid", 64'(ARID), 64'(IDLE_ID));
    chk("sb_drained", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    logic [DATA_W-1:0] held;
    logic ok;
    int lat;

    //             addr        len ar  nb bad rsp    id gap err
    tbl[0] = '{32'h0000_1000,  0, 0,  1, -1, 2'b00, -1, 0, 2'b00};
    tbl[1] = '{32'h0000_2000,  3, 4,  4, -1, 2'b00, -1, 2, 2'b00};
    tbl[2] = '{32'h0000_3000,  3, 1,  4,  2, 2'b10, -1, 1, 2'b01};
    tbl[3] = '{32'h0000_4000,  3, 0,  4, -1, 2'b00, -1, 0, 2'b00};
    tbl[4] = '{32'h0000_5000,  3, 0,  2, -1, 2'b00, -1, 0, 2'b01};
    tbl[5] = '{32'h0000_6000,  1, 0,  3, -1, 2'b00, -1, 1, 2'b01};
    tbl[6] = '{32'h0000_7000, 15, 2, 16, -1, 2'b00, -1, 0, 2'b00};
    tbl[7] = '{32'h0000_8000,  2, 0,  3, -1, 2'b00,  0, 0, 2'b01};
    tbl[8] = '{32'h0000_9000,  2, 1,  3,  1, 2'b11, -1, 3, 2'b01};
    tbl[9] = '{32'h0000_A000,  1, 0,  2,  0, 2'b01, -1, 0, 2'b01};

    #12;
    chk("rst_arid", 64'(ARID), 64'(IDLE_ID));
    chk("rst_arvalid", 64'(ARVALID), 64'd0);
    chk("rst_rready", 64'(RREADY), 64'd0);
    chk("rst_outputs", 64'({busy_o, beat_o, done_o, err_o}), 64'd0);
    chk("rst_rdata", 64'(rdata_o), 64'd0);
    chk("arsize", 64'(ARSIZE), 64'd2);
    chk("arburst", 64'(ARBURST), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    step();

    // Minimum latency: ARREADY and RVALID already high when the request arrives.
    ARREADY = 1'b1;
    RVALID  = 1'b1;
    RDATA   = 32'hDEAD_BEEF;
    RLAST   = 1'b1;
    addr_i  = 32'h0000_1000;
    len_i   = '0;
    sb.push_back('{4'd0, 32'hDEAD_BEEF});
    req_i = 1'b1;
    #1;
    chk("busy_comb_idle", 64'(busy_o), 64'd1);
    step();
    req_i = 1'b0;
    lat = 1;
    while (beat_o !== 1'b1 && lat < 10) begin
      step();
      lat++;
    end
    ARREADY = 1'b0;
    RVALID  = 1'b0;
    RLAST   = 1'b0;
    chk("min_latency", 64'(lat), 64'd3);
    chk("lat_done", 64'(done_o), 64'd1);
    chk("lat_err", 64'(err_o), 64'd0);

    // DONE with hold_i: data and done_o frozen, then back-to-back request.
    hold_i = 1'b1;
    held = rdata_o;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (done_o !== 1'b1 || rdata_o !== held || busy_o !== 1'b0) ok = 1'b0;
    end
    chk("hold_done", 64'(ok), 64'd1);
    chk("hold_data", 64'(rdata_o), 64'(32'hDEAD_BEEF));
    run_burst(tbl[0]);
    go_idle();

    for (int i = 0; i < 10; i++) begin
      run_burst(tbl[i]);
      go_idle();
    end

    // Reset mid-burst, and req_i ignored while in R.
    addr_i = 32'h0000_B000;
    len_i  = 4'd3;
    req_i  = 1'b1;
    step();
    req_i   = 1'b0;
    ARREADY = 1'b1;
    step();
    ARREADY = 1'b0;
    req_i   = 1'b1;
    len_i   = 4'd0;
    step();
    req_i = 1'b0;
    chk("req_ignored_arvalid", 64'(ARVALID), 64'd0);
    chk("req_ignored_rready", 64'(RREADY), 64'd1);
    RVALID = 1'b1;
    RDATA  = 32'h1234_5678;
    sb.push_back('{4'd0, 32'h1234_5678});
    step();
    RDATA = 32'hBAD0_BAD0;
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("midrst_arid", 64'(ARID), 64'(IDLE_ID));
    chk("midrst_rready", 64'(RREADY), 64'd0);
    chk("midrst_outputs", 64'({busy_o, beat_o, done_o, err_o}), 64'd0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    step();
    step();
    RVALID = 1'b0;
    chk("midrst_idle", 64'(RREADY), 64'd0);
    chk("midrst_sb", 64'(sb.size()), 64'd0);
    run_burst(tbl[3]);
    go_idle();

`ifdef AXI_RD_TIMEOUT_EN
    // Watchdog: ARREADY never arrives, abort after 8 AR cycles.
    addr_i = 32'h0000_C000;
    len_i  = 4'd2;
    req_i  = 1'b1;
    step();
    req_i = 1'b0;
    lat = 0;
    while (done_o !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    chk("timeout_cycles", 64'(lat), 64'd8);
    chk("timeout_err", 64'(err_o), 64'd2);
    chk("timeout_arvalid", 64'(ARVALID), 64'd0);
    chk("timeout_rready", 64'(RREADY), 64'd0);
    go_idle();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
